// File: rtl/key_capture_counter.sv
// Key capture stage: synchronizes and debounces key0 (capture) and key1 (clear), then latches
// the switch word and counts accepted presses. Build macro POPCOUNT_ACC_EN: captures add popcount(sw) instead of 1.

// Per-key conditioning: 2-FF synchronizer, four-state debounce FSM, rising-edge pulse.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic en,
  output logic rise
);

  // Holds 0..DB_CYCLES-2; DB_CYCLES is expected to be at least 2.
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 2);

  // Bit 1 of the encoding is the debounced level, so deb is a plain state decode.
  localparam logic [1:0] S_LOW  = 2'b00;
  localparam logic [1:0] W_HIGH = 2'b01;
  localparam logic [1:0] S_HIGH = 2'b10;
  localparam logic [1:0] W_LOW  = 2'b11;

  logic          s1;
  logic          s2;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          deb;
  logic          deb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop is assigned with <= so all registers sample the same pre-edge values.
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= S_LOW;
      cnt   <= '0;
      deb_d <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      deb_d <= deb;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case statement can infer a latch.
    state_nxt = state;
    cnt_nxt   = '0;
    if (!en) begin
      // Bypass: park in the stable state that matches s2, so deb follows s2 one clock later.
      state_nxt = s2 ? S_HIGH : S_LOW;
    end else begin
      case (state)
        S_LOW: begin
          if (s2) state_nxt = W_HIGH;
        end
        W_HIGH: begin
          if (!s2)                  state_nxt = S_LOW;
          else if (cnt == CNT_LAST) state_nxt = S_HIGH;
          else                      cnt_nxt   = cnt + CW'(1);
        end
        S_HIGH: begin
          if (!s2) state_nxt = W_LOW;
        end
        W_LOW: begin
          if (s2)                   state_nxt = S_HIGH;
          else if (cnt == CNT_LAST) state_nxt = S_LOW;
          else                      cnt_nxt   = cnt + CW'(1);
        end
        default: state_nxt = S_LOW;
      endcase
    end
  end

  assign deb  = state[1];
  assign rise = deb & ~deb_d;

endmodule

module key_capture_counter #(
  parameter int DB_CYCLES = 500000,
  parameter int REG_W     = 10,
  parameter int CNT_W     = 8
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic [4:0]       btn_i,
  input  logic [10:0]      sw_i,
  output logic [REG_W-1:0] register_o,
  output logic [CNT_W-1:0] counter_o,
  output logic             press_o
);

  logic             press;
  logic             clr;
  logic [CNT_W-1:0] inc;
  logic             unused_btn;

  assign unused_btn = ^btn_i[3:1];

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key0 (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .raw   (btn_i[0]),
    .en    (sw_i[10]),
    .rise  (press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key1 (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .raw   (btn_i[4]),
    .en    (sw_i[10]),
    .rise  (clr)
  );

`ifdef POPCOUNT_ACC_EN
  function automatic logic [CNT_W-1:0] popcount(input logic [REG_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < REG_W; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  assign inc = popcount(sw_i[REG_W-1:0]);
`else
  assign inc = CNT_W'(1);
`endif

  // Clear has priority over a coincident capture; press_o still reports the press.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      register_o <= '0;
      counter_o  <= '0;
    end else if (clr) begin
      register_o <= '0;
      counter_o  <= '0;
    end else if (press) begin
      register_o <= sw_i[REG_W-1:0];
      counter_o  <= counter_o + inc;
    end
  end

  assign press_o = press;

endmodule

// File: tb/tb_key_capture_counter.sv
// Self-checking bench for key_capture_counter: directed scenarios plus randomized key/switch traffic
// compared every cycle against a run-length behavioural model. Honours POPCOUNT_ACC_EN.
`timescale 1ns/100ps

module tb_key_capture_counter;

  localparam int DB = 4;

  logic        clk_50m;
  logic        rst_n;
  logic [4:0]  btn_i;
  logic [10:0] sw_i;
  logic [9:0]  register_o;
  logic [7:0]  counter_o;
  logic        press_o;

  int checks;
  int failures;
  int press_seen;

  // Model state: 2-sample delay line per key, filtered level, run length of disagreeing samples.
  logic [1:0] m_pipe [2];
  logic       m_deb  [2];
  int         m_run  [2];
  logic [9:0] m_reg;
  int         m_cnt;
  logic       m_press;
  logic       m_clr;

  key_capture_counter #(.DB_CYCLES(DB), .REG_W(10), .CNT_W(8)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .btn_i      (btn_i),
    .sw_i       (sw_i),
    .register_o (register_o),
    .counter_o  (counter_o),
    .press_o    (press_o)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int inc_of(input logic [9:0] v);
`ifdef POPCOUNT_ACC_EN
    return $countones(v);
`else
    return (v === v) ? 1 : 1;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pipe[k] = 2'b00;
      m_deb[k]  = 1'b0;
      m_run[k]  = 0;
    end
    m_reg   = '0;
    m_cnt   = 0;
    m_press = 1'b0;
    m_clr   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [1:0] raw;
    logic [1:0] rise;
    logic       s2;
    logic       nd;
    if (m_clr) begin
      m_reg = '0;
      m_cnt = 0;
    end else if (m_press) begin
      m_reg = sw_i[9:0];
      m_cnt = (m_cnt + inc_of(sw_i[9:0])) % 256;
    end
    raw = {btn_i[4], btn_i[0]};
    for (int k = 0; k < 2; k++) begin
      s2 = m_pipe[k][1];
      nd = m_deb[k];
      if (!sw_i[10]) begin
        nd       = s2;
        m_run[k] = 0;
      end else if (s2 != m_deb[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          nd       = s2;
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
      rise[k]   = nd & ~m_deb[k];
      m_deb[k]  = nd;
      m_pipe[k] = {m_pipe[k][0], raw[k]};
    end
    m_press = rise[0];
    m_clr   = rise[1];
  endtask

  // One clock: model at the rising edge, compare all outputs at the falling edge.
  task automatic tick();
    @(posedge clk_50m);
    model_edge();
    @(negedge clk_50m);
    if (press_o === 1'b1) press_seen++;
    check("register_o", 32'(register_o), 32'(m_reg));
    check("counter_o",  32'(counter_o),  m_cnt);
    check("press_o",    32'(press_o),    32'(m_press));
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic press_key0(input logic [9:0] v);
    sw_i[9:0] = v;
    btn_i[0]  = 1'b1;
    cyc(8);
    btn_i[0]  = 1'b0;
    cyc(8);
  endtask

  task automatic clear_key1();
    btn_i[4] = 1'b1;
    cyc(8);
    btn_i[4] = 1'b0;
    cyc(8);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    press_seen = 0;
    btn_i      = '0;
    sw_i       = '0;
    rst_n      = 1'b0;
    model_reset();

    // Reset state
    #23;
    check("rst_register", 32'(register_o), 32'h0);
    check("rst_counter",  32'(counter_o),  32'h0);
    check("rst_press",    32'(press_o),    32'h0);
    #4 rst_n = 1'b1;
    cyc(3);

    // Bypass latency: rise sampled at edge N -> press_o in (N+2, N+3), outputs at N+3
    sw_i     = 11'h155;
    btn_i[0] = 1'b1;
    tick();
    check("lat_press_n0", 32'(press_o), 32'h0);
    tick();
    check("lat_press_n1", 32'(press_o), 32'h0);
    tick();
    check("lat_press_n2", 32'(press_o), 32'h1);
    check("lat_cnt_n2",   32'(counter_o), 32'h0);
    tick();
    check("lat_press_n3", 32'(press_o),    32'h0);
    check("lat_reg_n3",   32'(register_o), 32'h155);
    check("lat_cnt_n3",   32'(counter_o),  inc_of(10'h155));
    press_seen = 0;
    cyc(50);
    check("hold_no_press", press_seen, 0);
    check("hold_cnt",      32'(counter_o), inc_of(10'h155));
    btn_i[0] = 1'b0;
    cyc(6);

    // Async reset mid-count with counter 0x37 and register 0x2AA
    clear_key1();
`ifdef POPCOUNT_ACC_EN
    repeat (11) press_key0(10'h2AA);
`else
    repeat (55) press_key0(10'h2AA);
`endif
    check("pre_rst_cnt", 32'(counter_o),  32'h37);
    check("pre_rst_reg", 32'(register_o), 32'h2AA);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(counter_o),  32'h0);
    check("async_rst_reg", 32'(register_o), 32'h0);
    rst_n = 1'b1;
    model_reset();
    cyc(3);

    // Wrap
    clear_key1();
`ifdef POPCOUNT_ACC_EN
    repeat (25) press_key0(10'h3FF);
    check("wrap_pre", 32'(counter_o), 32'd250);
    press_key0(10'h3FF);
    check("wrap_post", 32'(counter_o), 32'd4);
`else
    repeat (255) press_key0(10'($urandom));
    check("wrap_pre", 32'(counter_o), 32'd255);
    press_key0(10'h0F0);
    check("wrap_post", 32'(counter_o), 32'd0);
`endif

    // Simultaneous key0 and key1: clear wins, one press pulse
    press_key0(10'h0A5);
    sw_i[9:0]  = 10'h1C3;
    press_seen = 0;
    btn_i      = 5'b10001;
    cyc(6);
    check("simul_press_cnt", press_seen, 1);
    check("simul_reg",       32'(register_o), 32'h0);
    check("simul_cnt",       32'(counter_o),  32'h0);
    btn_i = '0;
    cyc(6);

    // Mode toggle while key0 held: only the original press
    press_seen = 0;
    sw_i       = 11'h011;
    btn_i[0]   = 1'b1;
    cyc(6);
    sw_i[10] = 1'b1;
    cyc(10);
    sw_i[10] = 1'b0;
    cyc(5);
    check("toggle_press_cnt", press_seen, 1);
    btn_i[0] = 1'b0;
    cyc(6);

    // Debounce glitch rejection
    sw_i[10] = 1'b1;
    cyc(6);
    clear_key1();
    press_seen = 0;
    sw_i[9:0]  = 10'h07E;
    repeat (3) begin
      btn_i[0] = 1'b1;
      cyc(3);
      btn_i[0] = 1'b0;
      cyc(8);
    end
    check("glitch_press_cnt", press_seen, 0);
    check("glitch_cnt",       32'(counter_o), 32'h0);
    btn_i[0] = 1'b1;
    cyc(6);
    btn_i[0] = 1'b0;
    cyc(10);
    check("db_press_cnt", press_seen, 1);
    check("db_cnt",       32'(counter_o),  inc_of(10'h07E));
    check("db_reg",       32'(register_o), 32'h07E);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      btn_i = {($urandom_range(0, 5) == 0), 3'($urandom), ($urandom_range(0, 1) == 1)};
      sw_i[9:0] = 10'($urandom);
      if ($urandom_range(0, 7) == 0) sw_i[10] = ~sw_i[10];
      cyc($urandom_range(1, 8));
    end
    btn_i = '0;
    cyc(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
